mc_ctrl: RTL and testbench
==========================

# mc_ctrl

Multi-cycle control FSM for the SCPU datapath. Sequences one shared memory port, one ALU and the register file through fetch, decode, execute, memory and write-back steps. Memory accesses use a ready handshake so the memory may insert wait states. Supports the single-cycle instruction set: add/sub/and/or/slt/sltu/addu/subu, addi, ori, lw, sw, beq, bne, j and jal.

## Interface
- No parameters. All encodings are fixed constants.
- `clk` in 1: the single clock; all state changes occur on its rising edge.
- `rst` in 1: synchronous, active-high reset.
- `Op` in 6: opcode from the IR. Stable from DECODE until the next FETCH.
- `Funct` in 6: funct field from the IR.
- `Zero` in 1: ALU zero flag. Combinational and valid in the same cycle.
- `mem_ready` in 1: memory completes the current read or write this cycle.
- `PCWrite` out 1: load the PC.
- `IRWrite` out 1: load the IR from memory read data.
- `IorD` out 1: address select. 0 = PC, 1 = ALUOut.
- `MemRead` out 1: memory read request.
- `MemWrite` out 1: memory write request.
- `RegWrite` out 1: register file write.
- `EXTOp` out 1: 1 = sign-extend the immediate, 0 = zero-extend.
- `ALUSrcA` out 1: ALU A select. 0 = PC, 1 = rs.
- `ALUSrcB` out 2: ALU B select. 00 = rt, 01 = 4, 10 = ext(imm), 11 = ext(imm)<<2.
- `ALUOp` out 3: NOP 000, ADD 001, SUB 010, AND 011, OR 100, SLT 101, SLTU 110.
- `PCSource` out 2: 00 = ALU result, 01 = ALUOut (branch target), 10 = jump target.
- `GPRSel` out 2: write register select. RD 00, RT 01, reg 31 10.
- `WDSel` out 2: write data select. ALU 00, MEM 01, PC 10.
- `instr_done` out 1: one-cycle pulse in the final cycle of each instruction.
- `illegal` out 1: high while in TRAP.
- `state` out 4: current state, for debug.

## Operation
- Outputs decode from the state register plus `Op`, `Funct`, `Zero` and `mem_ready`. They are not registered.
- Any output not listed for a state is 0 in that state.
- FETCH (0):
  - Asserts IorD=0, MemRead, ALUSrcA=0, ALUSrcB=01, ALUOp=ADD, PCSource=00.
  - IRWrite and PCWrite are asserted only when `mem_ready`=1.
  - Holds until `mem_ready`=1, then goes to DECODE.
- DECODE (1):
  - Asserts ALUSrcA=0, ALUSrcB=11, EXTOp=1, ALUOp=ADD, so the branch target lands in ALUOut.
  - Next state by opcode: R-type → EXEC_R; addi/ori → EXEC_I; lw/sw → MEMADR; beq/bne → BRANCH; j/jal → JUMP; anything else → TRAP.
  - An R-type with an unsupported funct → TRAP.
- MEMADR (2): asserts ALUSrcA=1, ALUSrcB=10, EXTOp=1, ALUOp=ADD. lw → MEMRD, sw → MEMWR.
- MEMRD (3): asserts IorD=1 and MemRead. Holds until `mem_ready`, then goes to MEMWB.
- MEMWB (4): asserts RegWrite, GPRSel=RT, WDSel=MEM and `instr_done`. → FETCH.
- MEMWR (5):
  - Asserts IorD=1 and MemWrite, held until `mem_ready`.
  - `instr_done` is asserted in the `mem_ready` cycle. → FETCH.
- EXEC_R (6): asserts ALUSrcA=1, ALUSrcB=00, with ALUOp decoded from funct:
  - add/addu = ADD; sub/subu = SUB; and = AND; or = OR; slt = SLT; sltu = SLTU.
  - → RWB.
- RWB (7): asserts RegWrite, GPRSel=RD, WDSel=ALU, `instr_done`. → FETCH.
- EXEC_I (8): asserts ALUSrcA=1, ALUSrcB=10, then → IWB.
  - addi: EXTOp=1, ALUOp=ADD.
  - ori: EXTOp=0, ALUOp=OR.
- IWB (9): asserts RegWrite, GPRSel=RT, WDSel=ALU, `instr_done`. → FETCH.
- BRANCH (10): asserts ALUSrcA=1, ALUSrcB=00, ALUOp=SUB, PCSource=01, `instr_done`. → FETCH.
  - PCWrite = (beq & Zero) | (bne & ~Zero).
- JUMP (11): asserts PCSource=10, PCWrite, `instr_done`. → FETCH.
  - jal additionally asserts RegWrite, GPRSel=31, WDSel=PC. The PC already holds PC+4 at this point.
- TRAP (12): asserts `illegal`. All write enables are 0. Stays in TRAP until `rst`.
- Unused encodings 13–15 → FETCH next cycle, with all write enables 0.

## Timing
- Reset:
  - While `rst`=1, every write enable (PCWrite, IRWrite, RegWrite, MemWrite) and `instr_done` is forced to 0.
  - The next state is FETCH.
  - After reset, `state`=0, `illegal`=0, MemRead=1, and all other outputs are 0.
- Reset asserted mid-instruction, including during a memory wait, abandons the instruction. No write enable is asserted in that cycle.
- Latency with `mem_ready` always 1:
  - R-type, addi, ori, sw: 4 cycles.
  - lw: 5 cycles.
  - beq, bne, j, jal: 3 cycles.
- Each cycle with `mem_ready`=0 in FETCH, MEMRD or MEMWR adds one cycle.
- `mem_ready` is ignored outside FETCH, MEMRD and MEMWR.
- MemRead and MemWrite are never asserted in the same cycle.
- `instr_done` asserts exactly once per completed instruction.

## Structure
- Package `mc_ctrl_pkg` holds the state encodings and the ALUOp, ALUSrcB, PCSource, GPRSel and WDSel constants. The existing single-cycle control shares the same ALUOp, GPRSel and WDSel values.
- One combinational sub-module, `mc_ctrl_dec`, decodes Op/Funct into one-hot instruction flags plus a `legal` flag.
- `mc_ctrl` holds the state register, the next-state logic and the output decode.

## Test plan
- `addi $1,$0,5` with `mem_ready`=1 → states 0,1,8,9; RegWrite, GPRSel=01, ALUOp=001, EXTOp=1 in IWB; `instr_done` in cycle 4.
- `lw` with `mem_ready` low for 2 cycles in MEMRD → 7 cycles total; IorD=1 and MemRead held through the wait; RegWrite with WDSel=01 only in MEMWB.
- `beq` with Zero=1 → PCWrite=1, PCSource=01 in BRANCH. With Zero=0 → PCWrite=0. `bne` gives the inverse.
- `jal` → JUMP asserts PCWrite, PCSource=10, RegWrite, GPRSel=10, WDSel=10; 3 cycles total.
- Op=6'h3F, or R-type with Funct=6'h00 → TRAP after DECODE; `illegal`=1; no write enables for 10 cycles; `rst` returns to FETCH.
- `rst` asserted in MEMWR while `mem_ready`=0 → MemWrite=0 that cycle; `state`=0 on the next cycle.

Source files
------------

// File: rtl/mc_ctrl_pkg.sv
// mc_ctrl_pkg: shared encodings for the SCPU multi-cycle control.
//   - state_t       : FSM state encodings (also driven out on the debug port)
//   - ALU_*         : ALUOp codes (shared with the single-cycle control)
//   - SRCB_*        : ALU B operand select
//   - PCSRC_*       : PC source select
//   - GPR_*, WD_*   : register-file write address / write data selects
//   - OP_*, F_*     : opcode and funct values of the supported instructions
package mc_ctrl_pkg;

    typedef enum logic [3:0] {
        S_FETCH  = 4'd0,
        S_DECODE = 4'd1,
        S_MEMADR = 4'd2,
        S_MEMRD  = 4'd3,
        S_MEMWB  = 4'd4,
        S_MEMWR  = 4'd5,
        S_EXEC_R = 4'd6,
        S_RWB    = 4'd7,
        S_EXEC_I = 4'd8,
        S_IWB    = 4'd9,
        S_BRANCH = 4'd10,
        S_JUMP   = 4'd11,
        S_TRAP   = 4'd12
    } state_t;

    localparam logic [2:0] ALU_NOP  = 3'b000;
    localparam logic [2:0] ALU_ADD  = 3'b001;
    localparam logic [2:0] ALU_SUB  = 3'b010;
    localparam logic [2:0] ALU_AND  = 3'b011;
    localparam logic [2:0] ALU_OR   = 3'b100;
    localparam logic [2:0] ALU_SLT  = 3'b101;
    localparam logic [2:0] ALU_SLTU = 3'b110;

    localparam logic [1:0] SRCB_RT     = 2'b00;
    localparam logic [1:0] SRCB_FOUR   = 2'b01;
    localparam logic [1:0] SRCB_IMM    = 2'b10;
    localparam logic [1:0] SRCB_IMMSH2 = 2'b11;

    localparam logic [1:0] PCSRC_ALU    = 2'b00;
    localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
    localparam logic [1:0] PCSRC_JUMP   = 2'b10;

    localparam logic [1:0] GPR_RD  = 2'b00;
    localparam logic [1:0] GPR_RT  = 2'b01;
    localparam logic [1:0] GPR_R31 = 2'b10;

    localparam logic [1:0] WD_ALU = 2'b00;
    localparam logic [1:0] WD_MEM = 2'b01;
    localparam logic [1:0] WD_PC  = 2'b10;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_JAL   = 6'h03;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_BNE   = 6'h05;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_ORI   = 6'h0D;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;

    localparam logic [5:0] F_ADD  = 6'h20;
    localparam logic [5:0] F_ADDU = 6'h21;
    localparam logic [5:0] F_SUB  = 6'h22;
    localparam logic [5:0] F_SUBU = 6'h23;
    localparam logic [5:0] F_AND  = 6'h24;
    localparam logic [5:0] F_OR   = 6'h25;
    localparam logic [5:0] F_SLT  = 6'h2A;
    localparam logic [5:0] F_SLTU = 6'h2B;

endpackage

// File: rtl/mc_ctrl_dec.sv
// mc_ctrl_dec: combinational instruction decoder.
//   op, funct    : IR opcode / funct fields
//   is_*         : one-hot instruction class flags (is_rtype only for a
//                  supported funct)
//   r_alu_op     : ALUOp for the R-type funct (NOP when not R-type)
//   legal        : the instruction is one the FSM can execute
module mc_ctrl_dec
    import mc_ctrl_pkg::*;
(
    input  logic [5:0] op,
    input  logic [5:0] funct,
    output logic       is_rtype,
    output logic       is_addi,
    output logic       is_ori,
    output logic       is_lw,
    output logic       is_sw,
    output logic       is_beq,
    output logic       is_bne,
    output logic       is_j,
    output logic       is_jal,
    output logic [2:0] r_alu_op,
    output logic       legal
);

    always_comb begin
        is_rtype = 1'b0;
        is_addi  = 1'b0;
        is_ori   = 1'b0;
        is_lw    = 1'b0;
        is_sw    = 1'b0;
        is_beq   = 1'b0;
        is_bne   = 1'b0;
        is_j     = 1'b0;
        is_jal   = 1'b0;
        r_alu_op = ALU_NOP;
        case (op)
            OP_RTYPE: begin
                // Only a recognised funct makes this a legal R-type.
                is_rtype = 1'b1;
                case (funct)
                    F_ADD, F_ADDU: r_alu_op = ALU_ADD;
                    F_SUB, F_SUBU: r_alu_op = ALU_SUB;
                    F_AND:         r_alu_op = ALU_AND;
                    F_OR:          r_alu_op = ALU_OR;
                    F_SLT:         r_alu_op = ALU_SLT;
                    F_SLTU:        r_alu_op = ALU_SLTU;
                    default:       is_rtype = 1'b0;
                endcase
            end
            OP_ADDI: is_addi = 1'b1;
            OP_ORI:  is_ori  = 1'b1;
            OP_LW:   is_lw   = 1'b1;
            OP_SW:   is_sw   = 1'b1;
            OP_BEQ:  is_beq  = 1'b1;
            OP_BNE:  is_bne  = 1'b1;
            OP_J:    is_j    = 1'b1;
            OP_JAL:  is_jal  = 1'b1;
            default: ;
        endcase
        legal = is_rtype | is_addi | is_ori | is_lw | is_sw |
                is_beq | is_bne | is_j | is_jal;
    end

endmodule

// File: rtl/mc_ctrl.sv
// mc_ctrl: multi-cycle control FSM for the SCPU datapath.
//   clk, rst          : clock, synchronous active-high reset
//   Op, Funct, Zero   : IR fields and ALU zero flag
//   mem_ready         : memory completes the current access this cycle
//   PCWrite..WDSel    : datapath controls, decoded combinationally from the
//                       state register and inputs
//   instr_done        : pulse in the final cycle of each instruction
//   illegal           : high while trapped on an unsupported instruction
//   state             : current state (debug)
module mc_ctrl
    import mc_ctrl_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic [5:0] Op,
    input  logic [5:0] Funct,
    input  logic       Zero,
    input  logic       mem_ready,
    output logic       PCWrite,
    output logic       IRWrite,
    output logic       IorD,
    output logic       MemRead,
    output logic       MemWrite,
    output logic       RegWrite,
    output logic       EXTOp,
    output logic       ALUSrcA,
    output logic [1:0] ALUSrcB,
    output logic [2:0] ALUOp,
    output logic [1:0] PCSource,
    output logic [1:0] GPRSel,
    output logic [1:0] WDSel,
    output logic       instr_done,
    output logic       illegal,
    output logic [3:0] state
);

    state_t     state_reg;
    state_t     state_next;

    logic       is_rtype;
    logic       is_addi;
    logic       is_ori;
    logic       is_lw;
    logic       is_sw;
    logic       is_beq;
    logic       is_bne;
    logic       is_j;
    logic       is_jal;
    logic [2:0] r_alu_op;
    logic       legal;

    mc_ctrl_dec u_dec (
        .op       (Op),
        .funct    (Funct),
        .is_rtype (is_rtype),
        .is_addi  (is_addi),
        .is_ori   (is_ori),
        .is_lw    (is_lw),
        .is_sw    (is_sw),
        .is_beq   (is_beq),
        .is_bne   (is_bne),
        .is_j     (is_j),
        .is_jal   (is_jal),
        .r_alu_op (r_alu_op),
        .legal    (legal)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg <= S_FETCH;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        PCWrite    = 1'b0;
        IRWrite    = 1'b0;
        IorD       = 1'b0;
        MemRead    = 1'b0;
        MemWrite   = 1'b0;
        RegWrite   = 1'b0;
        EXTOp      = 1'b0;
        ALUSrcA    = 1'b0;
        ALUSrcB    = SRCB_RT;
        ALUOp      = ALU_NOP;
        PCSource   = PCSRC_ALU;
        GPRSel     = GPR_RD;
        WDSel      = WD_ALU;
        instr_done = 1'b0;
        illegal    = 1'b0;
        state_next = S_FETCH;

        case (state_reg)
            S_FETCH: begin
                // PC+4 is computed by the ALU while the instruction is read.
                MemRead  = 1'b1;
                ALUSrcB  = SRCB_FOUR;
                ALUOp    = ALU_ADD;
                if (mem_ready) begin
                    IRWrite    = 1'b1;
                    PCWrite    = 1'b1;
                    state_next = S_DECODE;
                end else begin
                    state_next = S_FETCH;
                end
            end
            S_DECODE: begin
                // Speculatively form the branch target into ALUOut.
                ALUSrcB = SRCB_IMMSH2;
                EXTOp   = 1'b1;
                ALUOp   = ALU_ADD;
                if (!legal)                 state_next = S_TRAP;
                else if (is_rtype)          state_next = S_EXEC_R;
                else if (is_addi | is_ori)  state_next = S_EXEC_I;
                else if (is_lw | is_sw)     state_next = S_MEMADR;
                else if (is_beq | is_bne)   state_next = S_BRANCH;
                else                        state_next = S_JUMP;
            end
            S_MEMADR: begin
                ALUSrcA    = 1'b1;
                ALUSrcB    = SRCB_IMM;
                EXTOp      = 1'b1;
                ALUOp      = ALU_ADD;
                state_next = is_lw ? S_MEMRD : S_MEMWR;
            end
            S_MEMRD: begin
                IorD       = 1'b1;
                MemRead    = 1'b1;
                state_next = mem_ready ? S_MEMWB : S_MEMRD;
            end
            S_MEMWB: begin
                RegWrite   = 1'b1;
                GPRSel     = GPR_RT;
                WDSel      = WD_MEM;
                instr_done = 1'b1;
                state_next = S_FETCH;
            end
            S_MEMWR: begin
                IorD       = 1'b1;
                MemWrite   = 1'b1;
                instr_done = mem_ready;
                state_next = mem_ready ? S_FETCH : S_MEMWR;
            end
            S_EXEC_R: begin
                ALUSrcA    = 1'b1;
                ALUSrcB    = SRCB_RT;
                ALUOp      = r_alu_op;
                state_next = S_RWB;
            end
            S_RWB: begin
                RegWrite   = 1'b1;
                GPRSel     = GPR_RD;
                WDSel      = WD_ALU;
                instr_done = 1'b1;
                state_next = S_FETCH;
            end
            S_EXEC_I: begin
                ALUSrcA    = 1'b1;
                ALUSrcB    = SRCB_IMM;
                // ori zero-extends its immediate; addi sign-extends.
                EXTOp      = is_addi;
                ALUOp      = is_ori ? ALU_OR : ALU_ADD;
                state_next = S_IWB;
            end
            S_IWB: begin
                RegWrite   = 1'b1;
                GPRSel     = GPR_RT;
                WDSel      = WD_ALU;
                instr_done = 1'b1;
                state_next = S_FETCH;
            end
            S_BRANCH: begin
                // rs - rt sets Zero; ALUOut already holds the target.
                ALUSrcA    = 1'b1;
                ALUSrcB    = SRCB_RT;
                ALUOp      = ALU_SUB;
                PCSource   = PCSRC_ALUOUT;
                PCWrite    = (is_beq & Zero) | (is_bne & ~Zero);
                instr_done = 1'b1;
                state_next = S_FETCH;
            end
            S_JUMP: begin
                PCSource   = PCSRC_JUMP;
                PCWrite    = 1'b1;
                instr_done = 1'b1;
                // The PC was advanced in FETCH, so it is the link value.
                if (is_jal) begin
                    RegWrite = 1'b1;
                    GPRSel   = GPR_R31;
                    WDSel    = WD_PC;
                end
                state_next = S_FETCH;
            end
            S_TRAP: begin
                illegal    = 1'b1;
                state_next = S_TRAP;
            end
            default: state_next = S_FETCH;
        endcase

        // Reset abandons whatever is in flight without committing anything.
        if (rst) begin
            PCWrite    = 1'b0;
            IRWrite    = 1'b0;
            RegWrite   = 1'b0;
            MemWrite   = 1'b0;
            instr_done = 1'b0;
            state_next = S_FETCH;
        end
    end

    assign state = state_reg;

endmodule

// File: tb/tb_mc_ctrl.sv
// tb_mc_ctrl: random instruction stream with random memory wait states,
// checked per instruction against a step-table model, plus directed trap
// and reset scenarios.
module tb_mc_ctrl;

    logic       clk = 1'b0;
    logic       rst;
    logic [5:0] Op;
    logic [5:0] Funct;
    logic       Zero;
    logic       mem_ready;
    logic       PCWrite, IRWrite, IorD, MemRead, MemWrite, RegWrite, EXTOp, ALUSrcA;
    logic [1:0] ALUSrcB;
    logic [2:0] ALUOp;
    logic [1:0] PCSource, GPRSel, WDSel;
    logic       instr_done, illegal;
    logic [3:0] state;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    mc_ctrl dut (
        .clk(clk), .rst(rst), .Op(Op), .Funct(Funct), .Zero(Zero),
        .mem_ready(mem_ready), .PCWrite(PCWrite), .IRWrite(IRWrite), .IorD(IorD),
        .MemRead(MemRead), .MemWrite(MemWrite), .RegWrite(RegWrite), .EXTOp(EXTOp),
        .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB), .ALUOp(ALUOp), .PCSource(PCSource),
        .GPRSel(GPRSel), .WDSel(WDSel), .instr_done(instr_done), .illegal(illegal),
        .state(state)
    );

    // Expected per-instruction summary.
    typedef struct {
        int cycles; int alu; int ext; int n_rw; int gpr; int wd;
        int n_pcw; int pcs; int n_mw; int n_irw; int n_mrd; int n_iord;
    } exp_t;

    exp_t  exp_q[$];
    string str_q[$];
    string name_q[$];

    // Instruction table: 0..7 R-type variants, then addi ori lw sw beq bne j jal.
    logic [5:0] op_tab  [0:15] = '{6'h00, 6'h00, 6'h00, 6'h00, 6'h00, 6'h00, 6'h00, 6'h00,
                                   6'h08, 6'h0D, 6'h23, 6'h2B, 6'h04, 6'h05, 6'h02, 6'h03};
    logic [5:0] fn_tab  [0:7]  = '{6'h20, 6'h21, 6'h22, 6'h23, 6'h24, 6'h25, 6'h2A, 6'h2B};
    int         ralu_tab[0:7]  = '{1, 1, 2, 2, 3, 4, 5, 6};
    string      nm_tab  [0:15] = '{"add", "addu", "sub", "subu", "and", "or", "slt", "sltu",
                                   "addi", "ori", "lw", "sw", "beq", "bne", "j", "jal"};

    task automatic chk(input string name, input int act, input int req);
        checks++;
        if (act != req) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, req);
        end
    endtask

    // ---------------- model / driver ----------------
    string m_s;
    bit    m_sched[$];
    int    m_cycles;

    // One FSM step: a memory step repeats for each wait cycle and finishes
    // on the ready cycle; other steps take one cycle and see random ready.
    task automatic add_step(input int st, input bit is_mem, input int w);
        if (is_mem) begin
            for (int i = 0; i < w; i++) begin
                m_s = {m_s, $sformatf("%0d ", st)};
                m_sched.push_back(1'b0);
                m_cycles++;
            end
            m_s = {m_s, $sformatf("%0d ", st)};
            m_sched.push_back(1'b1);
        end else begin
            m_s = {m_s, $sformatf("%0d ", st)};
            m_sched.push_back(1'($urandom_range(0, 1)));
        end
        m_cycles++;
    endtask

    task automatic run_instr(input int k);
        exp_t e;
        int   wf, wm;
        bit   z, taken;
        wf = $urandom_range(0, 2);
        wm = $urandom_range(0, 3);
        z  = 1'($urandom_range(0, 1));
        Op    = op_tab[k];
        Funct = (k < 8) ? fn_tab[k] : 6'($urandom);
        Zero  = z;
        m_s = ""; m_sched.delete(); m_cycles = 0;
        e = '{default: 0};
        e.n_irw = 1;
        e.n_pcw = 1;
        e.n_mrd = wf + 1;
        add_step(0, 1'b1, wf);
        add_step(1, 1'b0, 0);
        if (k < 8) begin
            add_step(6, 1'b0, 0); add_step(7, 1'b0, 0);
            e.alu = ralu_tab[k]; e.n_rw = 1; e.gpr = 0; e.wd = 0;
        end else if (k == 8 || k == 9) begin
            add_step(8, 1'b0, 0); add_step(9, 1'b0, 0);
            e.alu = (k == 8) ? 1 : 4; e.ext = (k == 8) ? 1 : 0;
            e.n_rw = 1; e.gpr = 1; e.wd = 0;
        end else if (k == 10) begin
            add_step(2, 1'b0, 0); add_step(3, 1'b1, wm); add_step(4, 1'b0, 0);
            e.alu = 1; e.ext = 1; e.n_rw = 1; e.gpr = 1; e.wd = 1;
            e.n_mrd = wf + 1 + wm + 1; e.n_iord = wm + 1;
        end else if (k == 11) begin
            add_step(2, 1'b0, 0); add_step(5, 1'b1, wm);
            e.alu = 1; e.ext = 1; e.n_mw = wm + 1; e.n_iord = wm + 1;
        end else if (k == 12 || k == 13) begin
            add_step(10, 1'b0, 0);
            taken = (k == 12) ? z : !z;
            e.alu = 2;
            if (taken) begin e.n_pcw = 2; e.pcs = 1; end
        end else begin
            add_step(11, 1'b0, 0);
            e.n_pcw = 2; e.pcs = 2;
            if (k == 15) begin e.n_rw = 1; e.gpr = 2; e.wd = 2; end
        end
        e.cycles = m_cycles;
        exp_q.push_back(e);
        str_q.push_back(m_s);
        name_q.push_back(nm_tab[k]);
        foreach (m_sched[i]) begin
            mem_ready = m_sched[i];
            @(posedge clk); #1;
        end
    endtask

    // ---------------- monitor ----------------
    bit    mon_en = 1'b0;
    bit    act = 1'b0;
    bit    after_dec;
    string a_states;
    int    a_cycles, a_alu, a_ext, a_rw, a_gpr, a_wd, a_pcw, a_pcs, a_mw, a_irw, a_mrd, a_iord;

    always @(negedge clk) begin
        exp_t  e;
        string es, nm;
        if (!mon_en) begin
            act = 1'b0;
        end else begin
            if (!act) begin
                act = 1'b1; after_dec = 1'b0; a_states = "";
                a_cycles = 0; a_alu = 0; a_ext = 0; a_rw = 0; a_gpr = 0; a_wd = 0;
                a_pcw = 0; a_pcs = 0; a_mw = 0; a_irw = 0; a_mrd = 0; a_iord = 0;
            end
            a_cycles++;
            a_states = {a_states, $sformatf("%0d ", state)};
            if (after_dec) begin a_alu = int'(ALUOp); a_ext = int'(EXTOp); end
            after_dec = (state == 4'd1);
            if (RegWrite) begin a_rw++; a_gpr = int'(GPRSel); a_wd = int'(WDSel); end
            if (PCWrite) begin a_pcw++; a_pcs = int'(PCSource); end
            if (MemWrite) a_mw++;
            if (IRWrite)  a_irw++;
            if (MemRead)  a_mrd++;
            if (IorD)     a_iord++;
            chk("rd_wr_exclusive_or_illegal", int'((MemRead & MemWrite) | illegal), 0);
            if (instr_done) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_instr_done", 1, 0);
                end else begin
                    e  = exp_q.pop_front();
                    es = str_q.pop_front();
                    nm = name_q.pop_front();
                    checks++;
                    if (a_states != es) begin
                        errors++;
                        $display("FAIL %s states: got '%s' expected '%s'", nm, a_states, es);
                    end
                    chk({nm, " cycles"},  a_cycles, e.cycles);
                    chk({nm, " aluop"},   a_alu,    e.alu);
                    chk({nm, " extop"},   a_ext,    e.ext);
                    chk({nm, " regwr"},   a_rw,     e.n_rw);
                    chk({nm, " gprsel"},  a_gpr,    e.gpr);
                    chk({nm, " wdsel"},   a_wd,     e.wd);
                    chk({nm, " pcwr"},    a_pcw,    e.n_pcw);
                    chk({nm, " pcsrc"},   a_pcs,    e.pcs);
                    chk({nm, " memwr"},   a_mw,     e.n_mw);
                    chk({nm, " irwr"},    a_irw,    e.n_irw);
                    chk({nm, " memrd"},   a_mrd,    e.n_mrd);
                    chk({nm, " iord"},    a_iord,   e.n_iord);
                    $display("instr %-5s cycles=%0d states=%s", nm, a_cycles, a_states);
                end
                act = 1'b0;
            end else if (a_cycles > 40) begin
                chk("instr_timeout", a_cycles, 0);
                act = 1'b0;
            end
        end
    end

    // ---------------- directed helpers ----------------
    task automatic do_reset();
        rst = 1'b1;
        mem_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        chk("rst_we_off", int'(PCWrite | IRWrite | RegWrite | MemWrite | instr_done), 0);
        @(posedge clk); #1;
        rst = 1'b0;
    endtask

    task automatic trap_test(input logic [5:0] op, input logic [5:0] fn, input string nm);
        int we_cnt;
        Op = op; Funct = fn; Zero = 1'b0;
        do_reset();
        mem_ready = 1'b1;
        @(posedge clk); #1;
        @(posedge clk); #1;
        @(negedge clk);
        chk({nm, " trap_state"}, int'(state), 12);
        chk({nm, " illegal"}, int'(illegal), 1);
        we_cnt = 0;
        for (int i = 0; i < 10; i++) begin
            mem_ready = 1'($urandom_range(0, 1));
            @(negedge clk);
            if (PCWrite | IRWrite | RegWrite | MemWrite | instr_done) we_cnt++;
        end
        chk({nm, " trap_we_cycles"}, we_cnt, 0);
        chk({nm, " trap_hold"}, int'(state), 12);
        do_reset();
        @(negedge clk);
        chk({nm, " trap_exit_state"}, int'(state), 0);
        chk({nm, " trap_exit_illegal"}, int'(illegal), 0);
        $display("trap %s done", nm);
    endtask

    initial begin
        rst = 1'b1; Op = 6'h00; Funct = 6'h20; Zero = 1'b0; mem_ready = 1'b1;

        // Reset state.
        do_reset();
        @(negedge clk);
        chk("reset_state", int'(state), 0);
        chk("reset_illegal", int'(illegal), 0);
        chk("reset_memread", int'(MemRead), 1);
        chk("reset_memwrite", int'(MemWrite), 0);
        do_reset();

        // Random instruction stream.
        mon_en = 1'b1;
        for (int n = 0; n < 80; n++) begin
            run_instr($urandom_range(0, 15));
        end
        mon_en = 1'b0;
        chk("pending_expectations", exp_q.size(), 0);

        // Illegal opcode and illegal R-type funct.
        trap_test(6'h3F, 6'h20, "op3f");
        trap_test(6'h00, 6'h00, "funct00");

        // Reset during a stalled store.
        Op = 6'h2B; Funct = 6'h00;
        do_reset();
        mem_ready = 1'b1;
        @(posedge clk); #1;
        @(posedge clk); #1;
        @(posedge clk); #1;
        mem_ready = 1'b0;
        @(negedge clk);
        chk("memwr_state", int'(state), 5);
        chk("memwr_memwrite", int'(MemWrite), 1);
        rst = 1'b1;
        #1;
        chk("memwr_rst_memwrite", int'(MemWrite), 0);
        chk("memwr_rst_done", int'(instr_done | PCWrite | RegWrite), 0);
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        chk("memwr_rst_next_state", int'(state), 0);
        $display("reset during stalled sw done");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
